core_ctrl_fsm: RTL and testbench
================================

# core_ctrl_fsm

Multi-cycle control sequencer for the NPC single-issue core. Fetches through an instruction-memory handshake, decodes the RV32 opcode, and drives the immediate-extender select (`imm_src`). It also sequences the execute, memory and write-back enables and retires one instruction at a time. It stops the core on `ebreak`, on an unsupported opcode, or on a bus timeout.

## Interface
Parameters:
- `TIMEOUT`, default 256: maximum cycles to wait for `ifu_valid` or `lsu_valid` before a bus error.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ifu_valid`  in  1  instruction-fetch response valid.
- `ifu_rdata`  in  32  fetched instruction word.
- `lsu_valid`  in  1  load/store response valid.
- `ifu_req`  out  1  fetch request.
- `lsu_req`  out  1  data-memory request.
- `lsu_wen`  out  1  marks `lsu_req` as a store (1) or a load (0).
- `instr_q`  out  32  latched instruction.
- `imm_src`  out  imm_type (3)  extender select from the shared `imm_type` enum: `IMM_I`, `IMM_U`, `IMM_J`, `IMM_S`.
- `alu_a_pc`  out  1  ALU operand A is PC (1) or rs1 (0).
- `rf_wen`  out  1  register-file write enable, one-cycle pulse.
- `pc_wen`  out  1  PC update enable, one-cycle pulse.
- `pc_sel`  out  1  next PC is the ALU result (1) or PC+4 (0).
- `retire`  out  1  instruction-retired pulse.
- `instret`  out  32  count of retired instructions; wraps modulo 2^32.
- `halt`  out  1  core stopped (sticky).
- `illegal`  out  1  halt cause: unsupported instruction (sticky).
- `bus_err`  out  1  halt cause: handshake timeout (sticky).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **Reset values:**
  - State is IDLE.
  - All 1-bit outputs are 0.
  - `instr_q` = 0, `instret` = 0, `imm_src` = `IMM_I`.
- **IDLE → FETCH** unconditionally.
- **FETCH**
  - `ifu_req` = 1 for the whole state.
  - On `ifu_valid` = 1: latch `ifu_rdata` into `instr_q` and go to DECODE.
- **DECODE** (classifies `instr_q[6:0]`):
  - `0010011` (ALU-imm), `0000011` (load), `1100111` (jalr): `imm_src` = `IMM_I`.
  - `0110111` (lui), `0010111` (auipc): `imm_src` = `IMM_U`.
  - `1101111` (jal): `imm_src` = `IMM_J`.
  - `0100011` (store): `imm_src` = `IMM_S`.
  - `instr_q` = 32'h00100073 (ebreak): go to HALT; `illegal` stays 0.
  - Any other word: go to HALT with `illegal` = 1.
  - Otherwise go to EXEC.
  - `imm_src` is registered and holds until the next DECODE.
- **EXEC** (one cycle):
  - `alu_a_pc` = 1 for auipc and jal; 0 otherwise.
  - Load or store goes to MEM; everything else goes to WB.
- **MEM**
  - `lsu_req` = 1 for the whole state.
  - `lsu_wen` = 1 for a store.
  - On `lsu_valid` = 1, go to WB.
- **WB** (one cycle), then FETCH:
  - `pc_wen` = 1.
  - `retire` = 1 and `instret` increments.
  - `rf_wen` = 1 unless the instruction is a store.
  - `pc_sel` = 1 for jal and jalr.
- **HALT** is terminal until reset.
  - All request and enable outputs are 0.
  - `halt` = 1.
- `ifu_valid` is ignored outside FETCH; `lsu_valid` is ignored outside MEM.

## Timing
- **Request and enable outputs** are decoded from the registered state. Nothing is driven combinationally from inputs.
- **Request hold:** `ifu_req` and `lsu_req` stay high until the cycle in which the matching valid is sampled. The request drops in the next cycle.
- **Zero-wait latency:**
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each wait cycle in FETCH or MEM adds one cycle.
- **Watchdog:**
  - A counter clears on entry to FETCH or MEM and increments each cycle the matching valid is low.
  - If the counter equals `TIMEOUT-1` while valid is still low, the next state is HALT with `bus_err` = 1.
  - A valid arriving within `TIMEOUT` cycles of entry is accepted.
- **Halt flags:** `halt`, `illegal` and `bus_err` assert in the first HALT cycle and stay set.
- **`instret` wrap:** 32'hFFFFFFFF + 1 gives 0, with no flag.
- **Reset mid-operation:** asserting `rst_n` = 0 in any state forces reset values immediately, without waiting for a clock edge. An outstanding request is abandoned. After `rst_n` rises, the first FETCH cycle is the second clock edge (passing through IDLE).

## Test plan
- **Reset and first fetch:** assert `rst_n` = 0, then release → all outputs at reset values; `ifu_req` = 1 exactly 2 edges after release.
- **Zero-wait addi:** `ifu_rdata` = 32'h00500093 with `ifu_valid` = 1 → `imm_src` = `IMM_I`; `rf_wen`, `pc_wen` and `retire` pulse 3 cycles after the fetch accept; `instret` = 1.
- **Store with 3 wait cycles:** `ifu_rdata` = 32'h00112223, `lsu_valid` held low for 3 MEM cycles → `lsu_req` = `lsu_wen` = 1 for 4 cycles; `imm_src` = `IMM_S`; `rf_wen` = 0 in WB.
- **jal then lui:** jal = 32'h008000EF, then lui = 32'h123450B7 → jal: `imm_src` = `IMM_J`, `alu_a_pc` = 1, `pc_sel` = 1; lui: `imm_src` = `IMM_U`, `pc_sel` = 0; `instret` = 2.
- **Halts:**
  - 32'h00100073 → `halt` = 1, `illegal` = 0, `retire` never pulses.
  - 32'h00000063 → `halt` = 1, `illegal` = 1.
- **Timeout:**
  - With `TIMEOUT` = 4 and `ifu_valid` held low → `bus_err` = 1 after 4 FETCH cycles.
  - Valid on the 4th cycle → accepted, no error.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the NPC core: fetch handshake, RV32 opcode decode,
// execute/memory/write-back sequencing, retire counting and halt handling.

package core_ctrl_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_U = 3'd1,
    IMM_J = 3'd2,
    IMM_S = 3'd3
  } imm_type;
endpackage

// state  | meaning
// IDLE   | post-reset, waits one edge before the first fetch
// FETCH  | ifu_req high until ifu_valid, watchdog running
// DECODE | classify instr_q opcode, load imm_src
// EXEC   | single ALU cycle, alu_a_pc for auipc/jal
// MEM    | lsu_req high until lsu_valid, watchdog running
// WB     | register/PC write, retire pulse
// HALT   | terminal until reset
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_rdata,
  input  logic        lsu_valid,
  output logic        ifu_req,
  output logic        lsu_req,
  output logic        lsu_wen,
  output logic [31:0] instr_q,
  output imm_type     imm_src,
  output logic        alu_a_pc,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        pc_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halt,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   wdog;
  logic            armed;
  logic            to_illegal, to_bus_err;
  logic            wdog_hit;
  logic [6:0]      opcode;
  logic            op_alui, op_load, op_jalr, op_lui, op_auipc, op_jal, op_store;
  logic            op_known, op_ebreak;

  assign opcode    = instr_q[6:0];
  assign op_alui   = (opcode == 7'b0010011);
  assign op_load   = (opcode == 7'b0000011);
  assign op_jalr   = (opcode == 7'b1100111);
  assign op_lui    = (opcode == 7'b0110111);
  assign op_auipc  = (opcode == 7'b0010111);
  assign op_jal    = (opcode == 7'b1101111);
  assign op_store  = (opcode == 7'b0100011);
  assign op_known  = op_alui | op_load | op_jalr | op_lui | op_auipc | op_jal | op_store;
  assign op_ebreak = (instr_q == 32'h0010_0073);
  assign wdog_hit  = (wdog == WDOG_LAST);

  always_comb begin
    state_nxt  = state;
    to_illegal = 1'b0;
    to_bus_err = 1'b0;
    case (state)
      IDLE:   if (armed) state_nxt = FETCH;
      FETCH: begin
        if (ifu_valid) state_nxt = DECODE;
        else if (wdog_hit) begin
          state_nxt  = HALT;
          to_bus_err = 1'b1;
        end
      end
      DECODE: begin
        if (op_known) state_nxt = EXEC;
        else begin
          state_nxt  = HALT;
          to_illegal = ~op_ebreak;
        end
      end
      EXEC:   state_nxt = (op_load | op_store) ? MEM : WB;
      MEM: begin
        if (lsu_valid) state_nxt = WB;
        else if (wdog_hit) begin
          state_nxt  = HALT;
          to_bus_err = 1'b1;
        end
      end
      WB:     state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      wdog     <= '0;
      instr_q  <= '0;
      imm_src  <= IMM_I;
      ifu_req  <= 1'b0;
      lsu_req  <= 1'b0;
      lsu_wen  <= 1'b0;
      alu_a_pc <= 1'b0;
      rf_wen   <= 1'b0;
      pc_wen   <= 1'b0;
      pc_sel   <= 1'b0;
      retire   <= 1'b0;
      instret  <= '0;
      halt     <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      // armed delays the first fetch by one edge so it never races reset release
      armed <= 1'b1;
      state <= state_nxt;

      if ((state_nxt != state) && ((state_nxt == FETCH) || (state_nxt == MEM)))
        wdog <= '0;
      else if (((state == FETCH) && !ifu_valid) || ((state == MEM) && !lsu_valid))
        wdog <= wdog + CW'(1);

      if ((state == FETCH) && ifu_valid) instr_q <= ifu_rdata;

      if (state == DECODE) begin
        if (op_alui | op_load | op_jalr) imm_src <= IMM_I;
        else if (op_lui | op_auipc)      imm_src <= IMM_U;
        else if (op_jal)                 imm_src <= IMM_J;
        else if (op_store)               imm_src <= IMM_S;
      end

      ifu_req  <= (state_nxt == FETCH);
      lsu_req  <= (state_nxt == MEM);
      lsu_wen  <= (state_nxt == MEM) && op_store;
      alu_a_pc <= (state_nxt == EXEC) && (op_auipc | op_jal);
      rf_wen   <= (state_nxt == WB) && !op_store;
      pc_wen   <= (state_nxt == WB);
      pc_sel   <= (state_nxt == WB) && (op_jal | op_jalr);
      retire   <= (state_nxt == WB);
      if (state_nxt == WB) instret <= instret + 32'd1;

      halt    <= halt | (state_nxt == HALT);
      illegal <= illegal | to_illegal;
      bus_err <= bus_err | to_bus_err;
    end
  end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: instruction table plus hand-written reset, halt
// and watchdog sequences, all with hand-computed expectations.

module tb_core_ctrl_fsm;
  import core_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_valid, lsu_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_req, lsu_req, lsu_wen, alu_a_pc, rf_wen, pc_wen, pc_sel, retire;
  logic        halt, illegal, bus_err;
  logic [31:0] instr_q, instret;
  imm_type     imm_src;

  int checks = 0;
  int failures = 0;

  core_ctrl_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_valid(ifu_valid), .ifu_rdata(ifu_rdata),
    .lsu_valid(lsu_valid), .ifu_req(ifu_req), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .instr_q(instr_q), .imm_src(imm_src), .alu_a_pc(alu_a_pc), .rf_wen(rf_wen),
    .pc_wen(pc_wen), .pc_sel(pc_sel), .retire(retire), .instret(instret),
    .halt(halt), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          mem_wait;
    imm_type     imm;
    logic        apc;
    logic        rf;
    logic        psel;
    int          lsu_cyc;
    int          wen_cyc;
    int          lat;
  } vec_t;

  typedef struct {
    imm_type     imm;
    logic        apc;
    logic        rf;
    logic        psel;
    logic        pcw;
    int          lsu_cyc;
    int          wen_cyc;
    int          lat;
    int          ret;
    logic [31:0] cnt;
  } obs_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ifu_valid = 1'b0; lsu_valid = 1'b0; ifu_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_no_req", {31'd0, ifu_req}, 32'd0);
    @(posedge clk); #1;
    chk("second_edge_req", {31'd0, ifu_req}, 32'd1);
  endtask

  // Entered just after an edge with ifu_req high; leaves in the next FETCH cycle or in HALT.
  task automatic exec_instr(input logic [31:0] w, input int mem_wait, output obs_t o);
    int cyc = 1;
    int lreq = 0;
    o = '{IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 32'd0};
    ifu_rdata = w;
    ifu_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      cyc++;
      ifu_valid = 1'b0;
      lsu_valid = 1'b0;
      if (alu_a_pc) o.apc = 1'b1;
      if (lsu_req) begin
        lreq++;
        o.lsu_cyc++;
        if (lsu_wen) o.wen_cyc++;
        if (lreq == mem_wait + 1) lsu_valid = 1'b1;
      end
      if (retire) begin
        o.ret++;
        o.lat  = cyc;
        o.rf   = rf_wen;
        o.psel = pc_sel;
        o.pcw  = pc_wen;
        o.imm  = imm_src;
        o.cnt  = instret;
      end
      if (ifu_req || halt) break;
    end
  endtask

  initial begin
    obs_t o;
    int n;
    vecs[0] = '{32'h00500093, 0, IMM_I, 1'b0, 1'b1, 1'b0, 0, 0, 4};
    vecs[1] = '{32'h00112223, 3, IMM_S, 1'b0, 1'b0, 1'b0, 4, 4, 8};
    vecs[2] = '{32'h008000EF, 0, IMM_J, 1'b1, 1'b1, 1'b1, 0, 0, 4};
    vecs[3] = '{32'h123450B7, 0, IMM_U, 1'b0, 1'b1, 1'b0, 0, 0, 4};
    vecs[4] = '{32'h0040A103, 1, IMM_I, 1'b0, 1'b1, 1'b0, 2, 0, 6};
    vecs[5] = '{32'h00001117, 0, IMM_U, 1'b1, 1'b1, 1'b0, 0, 0, 4};
    vecs[6] = '{32'h000080E7, 0, IMM_I, 1'b0, 1'b1, 1'b1, 0, 0, 4};
    vecs[7] = '{32'h00112223, 0, IMM_S, 1'b0, 1'b0, 1'b0, 1, 1, 5};

    rst_n = 1'b0; ifu_valid = 1'b0; lsu_valid = 1'b0; ifu_rdata = '0;
    #12;
    chk("rst_ifu_req", {31'd0, ifu_req}, 32'd0);
    chk("rst_flags", {29'd0, halt, illegal, bus_err}, 32'd0);
    chk("rst_enables", {27'd0, rf_wen, pc_wen, pc_sel, retire, alu_a_pc}, 32'd0);
    chk("rst_lsu", {30'd0, lsu_req, lsu_wen}, 32'd0);
    chk("rst_instr_q", instr_q, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_imm_src", {29'd0, imm_src}, {29'd0, IMM_I});

    do_reset();
    for (int i = 0; i < 8; i++) begin
      exec_instr(vecs[i].instr, vecs[i].mem_wait, o);
      chk($sformatf("v%0d_imm", i), {29'd0, o.imm}, {29'd0, vecs[i].imm});
      chk($sformatf("v%0d_alu_a_pc", i), {31'd0, o.apc}, {31'd0, vecs[i].apc});
      chk($sformatf("v%0d_rf_wen", i), {31'd0, o.rf}, {31'd0, vecs[i].rf});
      chk($sformatf("v%0d_pc_sel", i), {31'd0, o.psel}, {31'd0, vecs[i].psel});
      chk($sformatf("v%0d_pc_wen", i), {31'd0, o.pcw}, 32'd1);
      chk($sformatf("v%0d_lsu_cycles", i), o.lsu_cyc, vecs[i].lsu_cyc);
      chk($sformatf("v%0d_wen_cycles", i), o.wen_cyc, vecs[i].wen_cyc);
      chk($sformatf("v%0d_latency", i), o.lat, vecs[i].lat);
      chk($sformatf("v%0d_retires", i), o.ret, 1);
      chk($sformatf("v%0d_instret", i), o.cnt, i + 1);
      chk($sformatf("v%0d_imm_hold", i), {29'd0, imm_src}, {29'd0, vecs[i].imm});
      chk($sformatf("v%0d_back_to_fetch", i), {30'd0, ifu_req, halt}, 32'd2);
    end

    // Asynchronous reset while a store waits in MEM.
    ifu_rdata = 32'h00112223;
    ifu_valid = 1'b1;
    n = 0;
    while (!lsu_req && n < 10) begin
      @(posedge clk); #1;
      ifu_valid = 1'b0;
      n++;
    end
    chk("midrst_reached_mem", {31'd0, lsu_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_lsu_req", {30'd0, lsu_req, lsu_wen}, 32'd0);
    chk("midrst_instret", instret, 32'd0);
    chk("midrst_instr_q", instr_q, 32'd0);
    chk("midrst_imm_src", {29'd0, imm_src}, {29'd0, IMM_I});

    // ebreak halts without illegal and never retires; ifu_valid ignored afterwards.
    do_reset();
    exec_instr(32'h00100073, 0, o);
    chk("ebreak_halt", {29'd0, halt, illegal, bus_err}, 32'b100);
    chk("ebreak_no_retire", o.ret, 0);
    ifu_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ifu_req || retire || rf_wen || pc_wen || lsu_req) n++;
    end
    ifu_valid = 1'b0;
    chk("ebreak_quiet", n, 0);
    chk("ebreak_sticky", {29'd0, halt, illegal, bus_err}, 32'b100);

    do_reset();
    exec_instr(32'h00000063, 0, o);
    chk("illegal_halt", {29'd0, halt, illegal, bus_err}, 32'b110);
    chk("illegal_no_retire", o.ret, 0);

    // Fetch watchdog: four FETCH cycles with ifu_valid low, then HALT.
    do_reset();
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ifu_req) n++;
      if (halt) break;
    end
    chk("fetch_to_cycles", n, 4);
    chk("fetch_to_flags", {29'd0, halt, illegal, bus_err}, 32'b101);
    chk("fetch_to_no_req", {31'd0, ifu_req}, 32'd0);

    // Valid arrives on the fourth FETCH cycle: accepted.
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("late_fetch_still_req", {30'd0, ifu_req, halt}, 32'd2);
    exec_instr(32'h00500093, 0, o);
    chk("late_fetch_retire", o.ret, 1);
    chk("late_fetch_no_err", {29'd0, halt, illegal, bus_err}, 32'd0);
    chk("late_fetch_instret", instret, 32'd1);

    // Load watchdog: lsu_valid never arrives.
    exec_instr(32'h0040A103, 100, o);
    chk("mem_to_lsu_cycles", o.lsu_cyc, 4);
    chk("mem_to_flags", {29'd0, halt, illegal, bus_err}, 32'b101);
    chk("mem_to_no_retire", o.ret, 0);
    chk("mem_to_instret", instret, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
